box_pixel_gen: RTL and testbench

BOX_PIXEL_GEN -- requirements
Module: box_pixel_gen

---
 rtl/box_pixel_gen.sv | 99 +++++++++
 tb/tb_box_pixel_gen.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/box_pixel_gen.sv
// Bouncing-box pixel generator: moves a square once per frame during vertical
// blank and produces one registered colour per pixel tick.
module box_pixel_gen #(
  parameter int          H_DISP   = 640,
  parameter int          V_DISP   = 480,
  parameter int          BOX_SIZE = 32,
  parameter int          STEP     = 2,
  parameter logic [2:0]  BG_COLOR = 3'b001
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       p_tick,
  input  logic       video_on,
  input  logic [9:0] pixel_x,
  input  logic [9:0] pixel_y,
  input  logic [2:0] box_color,
  input  logic       pause,
  output logic [2:0] rgb,
  output logic       frame_tick
);

  localparam logic [10:0] X_MAX   = 11'(H_DISP - BOX_SIZE);
  localparam logic [10:0] Y_MAX   = 11'(V_DISP - BOX_SIZE);
  localparam logic [10:0] STEP_W  = 11'(STEP);
  localparam logic [10:0] SIZE_W  = 11'(BOX_SIZE);
  localparam logic [9:0]  H_LAST  = 10'(H_DISP - 1);
  localparam logic [9:0]  V_LAST  = 10'(V_DISP - 1);
  localparam logic [9:0]  V_BLANK = 10'(V_DISP);

  logic [9:0] x_reg, y_reg;
  logic       dir_x, dir_y;
  logic       refresh;
  logic       box_hit, border_hit;
  logic [2:0] colour;
  logic [2:0] rgb_p0;
  logic       frame_tick_p0;

  // Returns {next_dir, next_pos}; clamps at 0 and lim so the box never wraps.
  function automatic logic [10:0] bounce(input logic [9:0] pos, input logic dir,
                                         input logic [10:0] lim);
    logic [10:0] result;
    if (dir) begin
      if ({1'b0, pos} + STEP_W >= lim) result = {1'b0, lim[9:0]};
      else                             result = {1'b1, pos + STEP_W[9:0]};
    end else begin
      if ({1'b0, pos} <= STEP_W) result = {1'b1, 10'd0};
      else                       result = {1'b0, pos - STEP_W[9:0]};
    end
    return result;
  endfunction

  function automatic logic [2:0] pixel_colour(input logic in_box, input logic on_border,
                                              input logic [2:0] bc);
    if (in_box)         return bc;
    else if (on_border) return 3'b111;
    else                return BG_COLOR;
  endfunction

  assign refresh = p_tick && (pixel_x == 10'd0) && (pixel_y == V_BLANK);

  assign box_hit = ({1'b0, pixel_x} >= {1'b0, x_reg}) &&
                   ({1'b0, pixel_x} <  {1'b0, x_reg} + SIZE_W) &&
                   ({1'b0, pixel_y} >= {1'b0, y_reg}) &&
                   ({1'b0, pixel_y} <  {1'b0, y_reg} + SIZE_W);

  assign border_hit = (pixel_x == 10'd0) || (pixel_x == H_LAST) ||
                      (pixel_y == 10'd0) || (pixel_y == V_LAST);

  assign colour = pixel_colour(box_hit, border_hit, box_color);

  // Box motion: only advances at the start of vertical blank, so drawing
  // always sees a stable position.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_reg <= '0;
      y_reg <= '0;
      dir_x <= 1'b1;
      dir_y <= 1'b1;
    end else if (refresh && !pause) begin
      {dir_x, x_reg} <= bounce(x_reg, dir_x, X_MAX);
      {dir_y, y_reg} <= bounce(y_reg, dir_y, Y_MAX);
    end
  end

  // Stage p0: registered pixel colour and frame pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rgb_p0        <= 3'b000;
      frame_tick_p0 <= 1'b0;
    end else begin
      frame_tick_p0 <= refresh;
      if (p_tick) rgb_p0 <= video_on ? colour : 3'b000;
    end
  end

  assign rgb        = rgb_p0;
  assign frame_tick = frame_tick_p0;

endmodule

// File: tb/tb_box_pixel_gen.sv
// Randomised self-checking bench for box_pixel_gen; box position is predicted
// as a closed-form triangle wave of the number of unpaused refreshes.
`timescale 1ns/1ps
module tb_box_pixel_gen;
  localparam int         H    = 640;
  localparam int         V    = 480;
  localparam int         BOX  = 32;
  localparam int         STEP = 2;
  localparam logic [2:0] BG   = 3'b001;

  logic       clk = 1'b0;
  logic       reset, p_tick, video_on, pause;
  logic [9:0] pixel_x, pixel_y;
  logic [2:0] box_color, rgb;
  logic       frame_tick;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         n_moves = 0;
  int         rgb_exp = 0;

  always #5 clk = ~clk;

  box_pixel_gen #(.H_DISP(H), .V_DISP(V), .BOX_SIZE(BOX), .STEP(STEP), .BG_COLOR(BG)) dut (
    .clk(clk), .reset(reset), .p_tick(p_tick), .video_on(video_on),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .box_color(box_color), .pause(pause),
    .rgb(rgb), .frame_tick(frame_tick)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Position after n moves: bounces between 0 and lim in STEP increments.
  function automatic int tri_pos(input int n, input int lim);
    int half, period, m;
    half   = lim / STEP;
    period = 2 * half;
    m      = n % period;
    return (m <= half) ? m * STEP : (period - m) * STEP;
  endfunction

  function automatic int box_x();
    return tri_pos(n_moves, H - BOX);
  endfunction

  function automatic int box_y();
    return tri_pos(n_moves, V - BOX);
  endfunction

  function automatic int ref_colour(input int x, input int y, input int bc);
    int bx, by;
    bx = box_x();
    by = box_y();
    if (x >= bx && x < bx + BOX && y >= by && y < by + BOX) return bc;
    if (x == 0 || x == H - 1 || y == 0 || y == V - 1) return 7;
    return int'(BG);
  endfunction

  task automatic tick_pixel(input int x, input int y, input logic von, input logic [2:0] bc);
    @(negedge clk);
    pixel_x = 10'(x); pixel_y = 10'(y); video_on = von; box_color = bc; p_tick = 1'b1;
    rgb_exp = von ? ref_colour(x, y, int'(bc)) : 0;
    @(posedge clk); #1;
    p_tick = 1'b0;
    chk("rgb", int'(rgb), rgb_exp);
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    p_tick = 1'b0;
    pixel_x = 10'($urandom_range(0, H - 1)); pixel_y = 10'($urandom_range(0, V - 1));
    video_on = 1'($urandom); box_color = 3'($urandom);
    @(posedge clk); #1;
    chk("rgb_hold", int'(rgb), rgb_exp);
  endtask

  task automatic do_refresh(input logic pz, input logic von);
    @(negedge clk);
    pixel_x = 10'd0; pixel_y = 10'(V); video_on = von; pause = pz; p_tick = 1'b1;
    box_color = 3'($urandom);
    rgb_exp = von ? ref_colour(0, V, int'(box_color)) : 0;
    @(posedge clk); #1;
    p_tick = 1'b0;
    if (!pz) n_moves++;
    chk("frame_tick_hi", int'(frame_tick), 1);
    chk("rgb_refresh", int'(rgb), rgb_exp);
    @(posedge clk); #1;
    chk("frame_tick_lo", int'(frame_tick), 0);
    pause = 1'b0;
  endtask

  task automatic probe(input int x, input int y);
    if (x >= 0 && x < H && y >= 0 && y < V)
      tick_pixel(x, y, 1'b1, 3'($urandom_range(2, 6)));
  endtask

  task automatic check_box();
    int bx, by;
    bx = box_x();
    by = box_y();
    probe(bx, by);
    probe(bx + BOX - 1, by + BOX - 1);
    probe(bx - 1, by);
    probe(bx, by - 1);
    probe(bx + BOX, by);
    probe(bx, by + BOX);
  endtask

  initial begin
    reset = 1'b1; p_tick = 1'b0; video_on = 1'b0; pause = 1'b0;
    pixel_x = '0; pixel_y = '0; box_color = 3'b010;
    #1;
    chk("reset_rgb", int'(rgb), 0);
    chk("reset_frame_tick", int'(frame_tick), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    tick_pixel(5, 5, 1'b1, 3'b110);
    tick_pixel(100, 100, 1'b1, 3'b110);
    tick_pixel(0, 200, 1'b1, 3'b110);

    do_refresh(1'b0, 1'b0);
    tick_pixel(1, 1, 1'b1, 3'b101);
    tick_pixel(2, 2, 1'b1, 3'b101);

    idle_cycle();
    idle_cycle();
    tick_pixel(10, 10, 1'b0, 3'b101);
    idle_cycle();

    while (n_moves < 305) begin
      do_refresh(1'b0, 1'b0);
      if (n_moves == 224 || n_moves == 225 || n_moves == 304 || n_moves == 305) check_box();
    end

    repeat (3) do_refresh(1'b1, 1'b0);
    check_box();
    do_refresh(1'b0, 1'b0);
    check_box();

    for (int i = 0; i < 300; i++) begin
      int act;
      act = int'($urandom_range(0, 9));
      if (act < 2) begin
        do_refresh(1'($urandom_range(0, 3) == 0), 1'($urandom));
      end else if (act == 2) begin
        idle_cycle();
      end else begin
        int x, y;
        if ($urandom_range(0, 3) == 0) begin
          x = int'($urandom_range(0, H - 1));
          y = int'($urandom_range(0, V - 1));
        end else begin
          x = box_x() - 3 + int'($urandom_range(0, BOX + 5));
          y = box_y() - 3 + int'($urandom_range(0, BOX + 5));
          if (x < 0) x = 0;
          if (x > H - 1) x = H - 1;
          if (y < 0) y = 0;
          if (y > V - 1) y = V - 1;
        end
        tick_pixel(x, y, 1'($urandom_range(0, 4) != 0), 3'($urandom));
      end
    end

    @(negedge clk);
    reset = 1'b1;
    n_moves = 0;
    rgb_exp = 0;
    #1;
    chk("reset2_rgb", int'(rgb), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (19) do_refresh(1'b0, 1'b0);
    tick_pixel(45, 45, 1'b1, 3'b011);
    @(negedge clk);
    pixel_x = 10'd0; pixel_y = 10'(V); video_on = 1'b1; pause = 1'b0; p_tick = 1'b1;
    @(posedge clk); #1;
    p_tick = 1'b0;
    n_moves++;
    chk("pre_reset_frame_tick", int'(frame_tick), 1);
    chk("pre_reset_rgb", int'(rgb), 7);
    #1;
    reset = 1'b1;
    #1;
    chk("async_rgb", int'(rgb), 0);
    chk("async_frame_tick", int'(frame_tick), 0);
    n_moves = 0;
    rgb_exp = 0;
    @(negedge clk);
    p_tick = 1'b1;
    @(posedge clk); #1;
    p_tick = 1'b0;
    chk("held_frame_tick", int'(frame_tick), 0);
    chk("held_rgb", int'(rgb), 0);
    @(negedge clk);
    reset = 1'b0;
    tick_pixel(5, 5, 1'b1, 3'b100);
    do_refresh(1'b0, 1'b0);
    check_box();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
